ps2_digit_entry: RTL and testbench

- Receives PS/2 keyboard frames, decodes Set-2 scan codes and builds a 4-digit decimal guess for the memorization game.
- Sits between the board's PS2Clk/PS2Data pins and the answer-checking/display logic.
- Outputs the guess as 4 BCD nibbles on userInt, plus a ready level once the player commits with Enter.

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_frame_rx.sv | 106 ++++++++++
 rtl/ps2_digit_entry.sv | 91 +++++++++
 tb/tb_ps2_digit_entry.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 digit-entry block: Set-2 scan codes,
// receiver/decoder state encodings and the scan-code to digit map.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_e;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_BREAK,
        DEC_EXT,
        DEC_EXT_BREAK
    } dec_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_t;

    function automatic digit_t digit_map(input logic [7:0] code);
        digit_t r;
        r.valid = 1'b1;
        r.digit = 4'd0;
        case (code)
            SC_D0:   r.digit = 4'd0;
            SC_D1:   r.digit = 4'd1;
            SC_D2:   r.digit = 4'd2;
            SC_D3:   r.digit = 4'd3;
            SC_D4:   r.digit = 4'd4;
            SC_D5:   r.digit = 4'd5;
            SC_D6:   r.digit = 4'd6;
            SC_D7:   r.digit = 4'd7;
            SC_D8:   r.digit = 4'd8;
            SC_D9:   r.digit = 4'd9;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect,
// 11-bit frame capture with odd-parity/stop check and mid-frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       code_valid_o,
    output logic [7:0] code_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    rx_state_e              state_q;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   parity_q;
    logic [TW-1:0]          tmo_q;
    logic                   code_valid_q;
    logic                   frame_err_q;
    logic [7:0]             code_q;

    logic clk_s;
    logic data_s;
    logic fall;
    logic frame_ok;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign fall     = clk_prev_q & ~clk_s;
    assign frame_ok = (^{shift_q, parity_q}) & data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            code_q       <= '0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    tmo_q <= '0;
                    if (fall && !data_s) begin
                        state_q   <= RX_RECV;
                        bit_cnt_q <= 4'd1;
                    end
                end
                RX_RECV: begin
                    if (fall) begin
                        tmo_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q <= 4'd8) begin
                            shift_q <= {data_s, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd9) begin
                            parity_q <= data_s;
                        end else begin
                            // stop edge: issue the code or flag the frame
                            state_q      <= RX_IDLE;
                            code_valid_q <= frame_ok;
                            frame_err_q  <= ~frame_ok;
                            code_q       <= shift_q;
                        end
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= RX_IDLE;
                        frame_err_q <= 1'b1;
                        tmo_q       <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
            endcase
        end
    end

    assign code_valid_o = code_valid_q;
    assign code_o       = code_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_digit_entry.sv
// PS/2 digit entry: Set-2 make/break decoding and a 4-digit BCD
// accumulator with backspace and Enter-to-commit.
module ps2_digit_entry
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2Clk,
    input  logic        PS2Data,
    output logic [15:0] userInt,
    output logic        ready,
    output logic [2:0]  digitCount,
    output logic        frameErr
);

    logic       code_valid;
    logic [7:0] code;
    logic       frame_err;
    digit_t     dm;

    dec_state_e  dec_q;
    logic [15:0] user_q;
    logic        ready_q;
    logic [2:0]  cnt_q;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (PS2Clk),
        .ps2_data_i  (PS2Data),
        .code_valid_o(code_valid),
        .code_o      (code),
        .frame_err_o (frame_err)
    );

    assign dm = digit_map(code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q   <= DEC_NORMAL;
            user_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else if (code_valid) begin
            unique case (dec_q)
                DEC_NORMAL: begin
                    unique case (1'b1)
                        code == SC_BREAK: dec_q <= DEC_BREAK;
                        code == SC_EXT:   dec_q <= DEC_EXT;
                        dm.valid: begin
                            if (ready_q) begin
                                user_q  <= {12'h000, dm.digit};
                                cnt_q   <= 3'd1;
                                ready_q <= 1'b0;
                            end else if (cnt_q < 3'd4) begin
                                user_q <= {user_q[11:0], dm.digit};
                                cnt_q  <= cnt_q + 3'd1;
                            end
                        end
                        code == SC_BKSP: begin
                            if (cnt_q != 3'd0 && !ready_q) begin
                                user_q <= user_q >> 4;
                                cnt_q  <= cnt_q - 3'd1;
                            end
                        end
                        code == SC_ENTER: begin
                            if (cnt_q == 3'd4) ready_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DEC_EXT: begin
                    dec_q <= (code == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
                end
                DEC_BREAK, DEC_EXT_BREAK: dec_q <= DEC_NORMAL;
            endcase
        end
    end

    assign userInt    = user_q;
    assign ready      = ready_q;
    assign digitCount = cnt_q;
    assign frameErr   = frame_err;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Scoreboard bench for ps2_digit_entry: serial PS/2 frames in,
// expected output changes queued by a digit-list reference model.
module tb_ps2_digit_entry;

    localparam int TMO  = 2000;
    localparam int SYNC = 2;
    localparam int HALF = 10;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        PS2Clk  = 1'b1;
    logic        PS2Data = 1'b1;
    logic [15:0] userInt;
    logic        ready;
    logic [2:0]  digitCount;
    logic        frameErr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        bit          err;
        logic [15:0] ui;
        bit          rdy;
        int          cnt;
        int          lo;
        int          hi;
    } exp_t;

    exp_t sb[$];

    int digs[$];
    bit m_ready = 1'b0;
    int pref    = 0;
    logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_digit_entry #(
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .userInt   (userInt),
        .ready     (ready),
        .digitCount(digitCount),
        .frameErr  (frameErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] m_ui();
        logic [15:0] v;
        v = 16'h0000;
        foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
        return v;
    endfunction

    task automatic push(input bit err, input int lo, input int hi);
        exp_t e;
        e.err = err;
        e.ui  = m_ui();
        e.rdy = m_ready;
        e.cnt = digs.size();
        e.lo  = lo;
        e.hi  = hi;
        sb.push_back(e);
    endtask

    // Reference: prefix bookkeeping plus a list of entered digits.
    task automatic model_frame(input logic [7:0] code, input int fc);
        logic [15:0] u0;
        bit r0;
        int n0;
        int d;
        u0 = m_ui();
        r0 = m_ready;
        n0 = digs.size();
        d  = -1;
        if (pref == 1 || pref == 3) begin
            pref = 0;
        end else if (pref == 2) begin
            pref = (code == 8'hF0) ? 3 : 0;
        end else if (code == 8'hF0) begin
            pref = 1;
        end else if (code == 8'hE0) begin
            pref = 2;
        end else begin
            for (int i = 0; i < 10; i++) if (dcodes[i] == code) d = i;
            if (d >= 0) begin
                if (m_ready) begin
                    digs.delete();
                    m_ready = 1'b0;
                end
                if (digs.size() < 4) digs.push_back(d);
            end else if (code == 8'h66) begin
                if (!m_ready && digs.size() > 0) void'(digs.pop_back());
            end else if (code == 8'h5A) begin
                if (digs.size() == 4) m_ready = 1'b1;
            end
        end
        if (m_ui() != u0 || m_ready != r0 || digs.size() != n0)
            push(1'b0, fc + SYNC + 2, fc + SYNC + 2);
    endtask

    task automatic fall_bit(input logic b, output int fc);
        @(negedge clk);
        PS2Data = b;
        repeat (HALF) @(negedge clk);
        PS2Clk = 1'b0;
        fc = cyc;
    endtask

    task automatic rise();
        repeat (HALF) @(negedge clk);
        PS2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad);
        logic [10:0] bits;
        int fc;
        bits = {1'b1, ~(^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            fall_bit(bits[i], fc);
            if (i == 10) begin
                if (bad) push(1'b1, fc + SYNC + 1, fc + SYNC + 1);
                else model_frame(code, fc);
            end
            rise();
        end
    endtask

    task automatic key(input logic [7:0] code);
        send_frame(code, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(code, 1'b0);
    endtask

    task automatic partial(input logic [7:0] code, input int n, output int fc);
        logic [10:0] bits;
        bits = {1'b1, ~(^code), code, 1'b0};
        fc = 0;
        for (int i = 0; i < n; i++) begin
            fall_bit(bits[i], fc);
            rise();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events never seen", sb.size());
            sb.delete();
        end
    endtask

    initial begin : monitor
        logic [15:0] p_ui;
        logic        p_rdy;
        logic [2:0]  p_cnt;
        exp_t        e;
        p_ui  = 16'h0;
        p_rdy = 1'b0;
        p_cnt = 3'd0;
        forever begin
            @(negedge clk);
            if (mon_en && (frameErr || userInt != p_ui || ready != p_rdy ||
                           digitCount != p_cnt)) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected: ui=%h rdy=%b cnt=%0d err=%b cyc=%0d",
                             userInt, ready, digitCount, frameErr, cyc);
                end else begin
                    e = sb.pop_front();
                    if (frameErr != e.err || userInt != e.ui || ready != e.rdy ||
                        int'(digitCount) != e.cnt || cyc < e.lo || cyc > e.hi) begin
                        failures++;
                        $display({"FAIL sb: got err=%b ui=%h rdy=%b cnt=%0d cyc=%0d",
                                  " expected err=%b ui=%h rdy=%b cnt=%0d cyc=[%0d,%0d]"},
                                 frameErr, userInt, ready, digitCount, cyc,
                                 e.err, e.ui, e.rdy, e.cnt, e.lo, e.hi);
                    end
                end
            end
            p_ui  = userInt;
            p_rdy = ready;
            p_cnt = digitCount;
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fc;
        int r;
        int kind;
        logic [7:0] c;

        repeat (3) @(negedge clk);
        chk("rst_userInt", int'(userInt), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_digitCount", int'(digitCount), 0);
        chk("rst_frameErr", int'(frameErr), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // 1234 then Enter
        key(8'h16);
        key(8'h1E);
        key(8'h26);
        key(8'h25);
        key(8'h5A);
        drain();
        chk("commit_1234", int'(userInt), 16'h1234);

        // new digit after commit, then overflow
        key(8'h46);
        key(8'h1E);
        key(8'h26);
        key(8'h25);
        key(8'h16);
        drain();
        chk("overflow_cnt", int'(digitCount), 4);

        for (int i = 0; i < 5; i++) key(8'h66);

        // 1,2,3, backspace, 7, Enter ignored
        key(8'h16);
        key(8'h1E);
        key(8'h26);
        key(8'h66);
        key(8'h3D);
        key(8'h5A);
        drain();
        chk("bksp_0127", int'(userInt), 16'h0127);
        chk("enter_ignored", int'(ready), 0);

        // parity error, then a good 2
        send_frame(8'h16, 1'b1);
        key(8'h1E);

        // timeout mid-frame, then a good 0
        key(8'h66);
        partial(8'h45, 6, fc);
        push(1'b1, fc + TMO, fc + TMO + 6);
        repeat (TMO + 50) @(negedge clk);
        key(8'h45);
        drain();
        chk("timeout_1270", int'(userInt), 16'h1270);

        // async reset mid-frame with two digits held
        key(8'h66);
        key(8'h66);
        drain();
        chk("pre_rst_cnt", int'(digitCount), 2);
        partial(8'h16, 6, fc);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_userInt", int'(userInt), 0);
        chk("async_ready", int'(ready), 0);
        chk("async_digitCount", int'(digitCount), 0);
        chk("async_frameErr", int'(frameErr), 0);
        digs.delete();
        m_ready = 1'b0;
        pref    = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        key(8'h16);
        drain();
        chk("post_rst_0001", int'(userInt), 16'h0001);

        // randomized key traffic
        for (int k = 0; k < 50; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5) c = dcodes[$urandom_range(0, 9)];
            else if (r < 7) c = 8'h66;
            else if (r < 9) c = 8'h5A;
            else c = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                key(c);
            end else if (kind == 7) begin
                send_frame(8'hE0, 1'b0);
                send_frame(c, 1'b0);
                send_frame(8'hE0, 1'b0);
                send_frame(8'hF0, 1'b0);
                send_frame(c, 1'b0);
            end else if (kind == 8) begin
                send_frame(c, 1'b1);
            end else begin
                send_frame(c, 1'b0);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
